perceptron_accumulator: RTL and testbench

- Sums N_INPUTS sign-magnitude fixed-point products from the upstream `fixed_point_multiplier`, then adds a bias term.
- Saturates the total back to the same sign-magnitude format and presents it, with a step-activation bit, on a valid/ready output.
- Sits between the multiplier array and the perceptron output and weight-update logic.
- Everything runs in one clock domain, and one dot product is in flight at a time.

---
 rtl/perceptron_accumulator_if.sv | 25 ++
 rtl/perceptron_accumulator.sv | 98 +++++++++
 tb/tb_perceptron_accumulator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/perceptron_accumulator_if.sv
// Product-in / result-out handshake bundle for perceptron_accumulator.
// master: the side feeding products/bias and consuming the result.
// slave : the accumulator itself.
interface perceptron_accumulator_if #(
  parameter int W = 33
);
  logic         product_valid_i;
  logic [W-1:0] product_i;
  logic         ready_o;
  logic [W-1:0] bias_i;
  logic         sum_valid_o;
  logic         sum_ready_i;
  logic [W-1:0] sum_o;
  logic         activation_o;

  modport master (
    output product_valid_i, product_i, bias_i, sum_ready_i,
    input  ready_o, sum_valid_o, sum_o, activation_o
  );

  modport slave (
    input  product_valid_i, product_i, bias_i, sum_ready_i,
    output ready_o, sum_valid_o, sum_o, activation_o
  );
endinterface

// File: rtl/perceptron_accumulator.sv
// perceptron_accumulator: sums N_INPUTS sign-magnitude products plus a bias,
// saturates back to sign-magnitude and presents it with a step activation.
// Optional macro PERCEPTRON_RELU_EN: sum_o becomes ReLU(total) instead of the
// signed saturated total (activation_o unaffected).
module perceptron_accumulator #(
  parameter int q_m      = 17,
  parameter int q_n      = 16,
  parameter int N_INPUTS = 4
) (
  input logic                    clk_i,
  input logic                    reset_ni,
  perceptron_accumulator_if.slave bus
);

  localparam int W  = q_m + q_n;
  localparam int CW = $clog2(N_INPUTS + 1);
  // Wide enough for (N_INPUTS+1) full-scale terms, so no internal overflow.
  localparam int AW = W + CW + 1;
  localparam logic [AW-1:0] MAX_MAG = {{(CW + 2){1'b0}}, {(W - 1){1'b1}}};

  typedef enum logic [1:0] {ACCUM, BIAS, OUT} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] count;
  logic [W-1:0]  sum_q;
  logic          sum_valid_q;
  logic          act_q;
  logic [AW-1:0] total;

  // Sign-magnitude -> two's complement; negative zero falls out as 0.
  function automatic logic [AW-1:0] to_tc(input logic [W-1:0] x);
    logic [AW-1:0] m;
    m = {{(AW - W + 1){1'b0}}, x[W-2:0]};
    return x[W-1] ? (~m + AW'(1)) : m;
  endfunction

  // Two's complement -> saturated sign-magnitude; zero always comes out +0.
  function automatic logic [W-1:0] sat(input logic [AW-1:0] t);
    logic [AW-1:0] m;
    logic [W-2:0]  mg;
    m  = t[AW-1] ? (~t + AW'(1)) : t;
    mg = (m > MAX_MAG) ? {(W - 1){1'b1}} : m[W-2:0];
`ifdef PERCEPTRON_RELU_EN
    if (t[AW-1]) return '0;
    return {1'b0, mg};
`else
    return {t[AW-1], mg};
`endif
  endfunction

  assign total            = acc + to_tc(bus.bias_i);
  assign bus.ready_o      = (state == ACCUM);
  assign bus.sum_valid_o  = sum_valid_q;
  assign bus.sum_o        = sum_q;
  assign bus.activation_o = act_q;

  // Control FSM plus accumulator, result and activation registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state       <= ACCUM;
      acc         <= '0;
      count       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      act_q       <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // ready_o is 1 here, so a valid beat is an accepted beat.
          if (bus.product_valid_i) begin
            acc   <= acc + to_tc(bus.product_i);
            count <= count + CW'(1);
            if (count == CW'(N_INPUTS - 1)) state <= BIAS;
          end
        end
        BIAS: begin
          // bias_i is only looked at on this edge.
          sum_q       <= sat(total);
          act_q       <= ~total[AW-1] & (|total);
          sum_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          // Products are ignored here; the result holds until taken.
          if (bus.sum_ready_i) begin
            sum_valid_q <= 1'b0;
            acc         <= '0;
            count       <= '0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_accumulator.sv
// Directed bench for perceptron_accumulator (N_INPUTS=4, q_m=17, q_n=16).
module tb_perceptron_accumulator;

  localparam int W = 33;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  perceptron_accumulator_if #(.W(W)) bus ();

  perceptron_accumulator #(.q_m(17), .q_n(16), .N_INPUTS(4)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [W-1:0] P_0_5  = 33'h0_0000_8000;
  localparam logic [W-1:0] P_0_25 = 33'h0_0000_4000;
  localparam logic [W-1:0] P_1_0  = 33'h0_0001_0000;
  localparam logic [W-1:0] N_1_0  = 33'h1_0001_0000;
  localparam logic [W-1:0] JUNK   = 33'h0_1234_5678;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Four beats, then the BIAS cycle; returns at the negedge after edge E+1.
  task automatic feed(input string tag, input logic [W-1:0] a, b, c, d, bias);
    logic [W-1:0] p[4];
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk({tag, " ready in ACCUM"}, 64'(bus.ready_o), 64'd1);
      bus.product_valid_i = 1'b1;
      bus.product_i       = p[i];
      bus.bias_i          = JUNK;
      @(posedge clk_i);
    end
    @(negedge clk_i);
    bus.product_valid_i = 1'b0;
    bus.bias_i          = bias;
    chk({tag, " ready in BIAS"}, 64'(bus.ready_o), 64'd0);
    chk({tag, " valid low in BIAS"}, 64'(bus.sum_valid_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.bias_i = JUNK;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] s, input logic act);
    chk({tag, " sum_valid"}, 64'(bus.sum_valid_o), 64'd1);
    chk({tag, " sum"}, 64'(bus.sum_o), 64'(s));
    chk({tag, " activation"}, 64'(bus.activation_o), 64'(act));
    chk({tag, " ready in OUT"}, 64'(bus.ready_o), 64'd0);
  endtask

  task automatic drain(input string tag);
    bus.sum_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.sum_ready_i = 1'b0;
    chk({tag, " valid after drain"}, 64'(bus.sum_valid_o), 64'd0);
    chk({tag, " ready after drain"}, 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    bus.product_valid_i = 1'b0;
    bus.product_i       = '0;
    bus.bias_i          = '0;
    bus.sum_ready_i     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset ready", 64'(bus.ready_o), 64'd1);
    chk("reset sum_valid", 64'(bus.sum_valid_o), 64'd0);
    chk("reset sum", 64'(bus.sum_o), 64'd0);
    chk("reset activation", 64'(bus.activation_o), 64'd0);
    reset_ni = 1'b1;

    // 1: 0.5 x4 + 0 = 2.0
    feed("t1", P_0_5, P_0_5, P_0_5, P_0_5, 33'h0);
    expect_out("t1", 33'h0_0002_0000, 1'b1);
    drain("t1");

    // 2: 0.5 - 1.5 + 0.25 + 0 - 0.25 = -1.0
    feed("t2", P_0_5, 33'h1_0001_8000, P_0_25, 33'h0, 33'h1_0000_4000);
`ifdef PERCEPTRON_RELU_EN
    expect_out("t2", 33'h0, 1'b0);
`else
    expect_out("t2", N_1_0, 1'b0);
`endif
    drain("t2");

    // 3: positive saturation
    feed("t3p", 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF);
    expect_out("t3p", 33'h0_FFFF_FFFF, 1'b1);
    drain("t3p");

    // 3: negative saturation
    feed("t3n", 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF);
`ifdef PERCEPTRON_RELU_EN
    expect_out("t3n", 33'h0, 1'b0);
`else
    expect_out("t3n", 33'h1_FFFF_FFFF, 1'b0);
`endif
    drain("t3n");

    // 4: cancelling products, negative-zero bias -> +0
    feed("t4", P_1_0, N_1_0, P_1_0, N_1_0, 33'h1_0000_0000);
    expect_out("t4", 33'h0, 1'b0);
    drain("t4");

    // 5: back-pressure in OUT while products are offered
    feed("t5", P_0_5, P_0_5, P_0_5, P_0_5, 33'h0);
    expect_out("t5", 33'h0_0002_0000, 1'b1);
    bus.product_valid_i = 1'b1;
    bus.product_i       = P_0_5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      expect_out("t5 hold", 33'h0_0002_0000, 1'b1);
    end
    // Release together with a product: that product must not be taken.
    bus.sum_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.sum_ready_i     = 1'b0;
    bus.product_valid_i = 1'b0;
    chk("t5 valid after drain", 64'(bus.sum_valid_o), 64'd0);
    feed("t5b", P_0_25, P_0_25, P_0_25, P_0_25, 33'h0);
    expect_out("t5b", P_1_0, 1'b1);
    drain("t5b");

    // 6: reset mid-vector discards the partial sum
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      bus.product_valid_i = 1'b1;
      bus.product_i       = 33'h0_0003_0000;
      @(posedge clk_i);
    end
    @(negedge clk_i);
    bus.product_valid_i = 1'b0;
    reset_ni            = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    chk("t6 ready", 64'(bus.ready_o), 64'd1);
    chk("t6 sum_valid", 64'(bus.sum_valid_o), 64'd0);
    chk("t6 sum", 64'(bus.sum_o), 64'd0);
    feed("t6b", P_0_25, P_0_25, P_0_25, P_0_25, 33'h0);
    expect_out("t6b", P_1_0, 1'b1);
    drain("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
